// File: rtl/adc_frame_sequencer.sv
// ADC acquisition sequencer: packs ADC samples into AXI-Stream frames through a
// 2-entry skid buffer, with frame counting, run control and a sticky overflow flag.
module adc_frame_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [CNT_WIDTH-1:0]  cfg_samples,
    input  logic [CNT_WIDTH-1:0]  cfg_frames,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  clr_overflow,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  ready,
    output logic                  frame_last,
    output logic                  running,
    output logic                  done,
    output logic                  overflow,
    output logic [CNT_WIDTH-1:0]  frame_count
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state;
    logic [CNT_WIDTH-1:0]  samples;
    logic [CNT_WIDTH-1:0]  frames;
    logic [CNT_WIDTH-1:0]  sample_cnt;
    logic                  done_pending;

    logic [DATA_WIDTH-1:0] buf_data [2];
    logic [1:0]            buf_last;
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            count;

    logic                  pop;
    logic                  push;
    logic                  sample_tlast;
    logic                  frame_done;
    logic                  start_ok;

    assign m_axis_tvalid = (count != 2'd0);
    assign m_axis_tdata  = buf_data[rd_ptr];
    assign m_axis_tlast  = buf_last[rd_ptr];
    assign pop           = m_axis_tvalid & m_axis_tready;

    // A full buffer still accepts a sample when the head leaves in the same cycle.
    assign ready         = (state == RUN) & ((count != 2'd2) | pop);
    assign push          = ready & s_valid & ~abort;
    assign sample_tlast  = (sample_cnt == samples - CNT_WIDTH'(1));
    assign frame_done    = push & sample_tlast & (frames != '0) &
                           (frame_count + CNT_WIDTH'(1) == frames);
    assign start_ok      = (state == IDLE) & start & (cfg_samples != '0);
    assign running       = (state != IDLE);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_last    <= '0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= s_data;
                buf_last[wr_ptr] <= sample_tlast;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= IDLE;
            samples      <= '0;
            frames       <= '0;
            sample_cnt   <= '0;
            frame_count  <= '0;
            done_pending <= 1'b0;
            done         <= 1'b0;
            frame_last   <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            done       <= 1'b0;
            frame_last <= pop & m_axis_tlast;

            // A lost sample in the same cycle as a clear keeps the flag set.
            if ((state == RUN) & s_valid & ~ready & ~abort) begin
                overflow <= 1'b1;
            end else if (clr_overflow | start_ok) begin
                overflow <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start_ok) begin
                        samples      <= cfg_samples;
                        frames       <= cfg_frames;
                        sample_cnt   <= '0;
                        frame_count  <= '0;
                        done_pending <= 1'b0;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        done_pending <= 1'b0;
                        state        <= DRAIN;
                    end else if (push) begin
                        if (sample_tlast) begin
                            sample_cnt  <= '0;
                            frame_count <= frame_count + CNT_WIDTH'(1);
                        end else begin
                            sample_cnt <= sample_cnt + CNT_WIDTH'(1);
                        end
                        if (frame_done) begin
                            done_pending <= 1'b1;
                            state        <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (count == 2'd0) begin
                        done         <= done_pending;
                        done_pending <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
